// File: rtl/tape_buffer_mem.sv
// Record/playback note store with auto-incrementing record/play pointers, tracked
// tape length, loop or one-shot playback, seek, and a valid-qualified read port.
module tape_buffer_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic              loop_en,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              seek_en,
    input  logic [ADDR_W-1:0] seek_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              empty,
    output logic              play_done,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_reg,    state_next;
    logic [ADDR_W:0]   length_reg,   length_next;
    logic [ADDR_W-1:0] rd_ptr_reg,   rd_ptr_next;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_word_reg;

    logic              do_write;
    logic              do_read;
    logic              full_w;
    logic              last_w;
    logic [ADDR_W-1:0] seek_target;

    assign full_w      = (length_reg == DEPTH_L);
    assign last_w      = ({1'b0, rd_ptr_reg} == (length_reg - 1'b1));
    assign seek_target = ({1'b0, seek_addr} < length_reg) ? seek_addr : '0;

    // Appending only, so the write pointer always equals the stored length.
    always_comb begin
        state_next  = state_reg;
        length_next = length_reg;
        rd_ptr_next = rd_ptr_reg;
        do_write    = 1'b0;
        do_read     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (seek_en)
                    rd_ptr_next = seek_target;
                if (rec_en && !play_en)
                    state_next = ST_REC;
                else if (play_en && !rec_en && (length_reg != '0))
                    state_next = ST_PLAY;
            end
            ST_REC: begin
                if (wr_valid && !full_w) begin
                    do_write    = 1'b1;
                    length_next = length_reg + 1'b1;
                end
                if (!rec_en)
                    state_next = ST_IDLE;
            end
            ST_PLAY: begin
                if (rd_req) begin
                    do_read = 1'b1;
                    if (!last_w)
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                    else if (loop_en)
                        rd_ptr_next = '0;
                    else
                        state_next = ST_DONE;
                end
                if (!play_en) begin
                    // Leaving at end of a one-shot tape rewinds, as leaving DONE does.
                    if (state_next == ST_DONE)
                        rd_ptr_next = '0;
                    state_next = ST_IDLE;
                end
                if (seek_en)
                    rd_ptr_next = seek_target;
            end
            default: begin
                if (!play_en) begin
                    state_next  = ST_IDLE;
                    rd_ptr_next = '0;
                end
            end
        endcase
        if (clear) begin
            state_next  = ST_IDLE;
            length_next = '0;
            rd_ptr_next = '0;
            do_write    = 1'b0;
            do_read     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            length_reg   <= '0;
            rd_ptr_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            length_reg   <= length_next;
            rd_ptr_reg   <= rd_ptr_next;
            rd_valid_reg <= do_read;
        end
    end

    // Storage and read word carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[length_reg[IDX_W-1:0]] <= wr_data;
        if (do_read)
            rd_word_reg <= mem[rd_ptr_reg[IDX_W-1:0]];
    end

    assign rd_data   = rd_valid_reg ? rd_word_reg : '0;
    assign rd_valid  = rd_valid_reg;
    assign length    = length_reg;
    assign full      = full_w;
    assign empty     = (length_reg == '0);
    assign play_done = (state_reg == ST_DONE);
    assign state     = state_reg;

endmodule

// File: tb/tb_tape_buffer_mem.sv
// Directed-vector bench for tape_buffer_mem on a 4-word tape with 3-bit pointers.
module tb_tape_buffer_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst, clear, rec_en, play_en, loop_en;
    logic              wr_valid, rd_req, seek_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] seek_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, full, empty, play_done;
    logic [ADDR_W:0]   length;
    logic [1:0]        state;

    int vec_cnt = 0;
    int err_cnt = 0;

    tape_buffer_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .rec_en(rec_en), .play_en(play_en),
        .loop_en(loop_en), .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req),
        .seek_en(seek_en), .seek_addr(seek_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .length(length), .full(full), .empty(empty), .play_done(play_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [DATA_W-1:0] exp);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; rec_en = 1'b0; play_en = 1'b0; loop_en = 1'b0;
        wr_valid = 1'b0; rd_req = 1'b0; seek_en = 1'b0; wr_data = '0; seek_addr = '0;
        step(); step();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_length", 32'(length), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);

        // Async reset in the middle of recording
        rec_en = 1'b1; step();
        write_word(8'hA1); write_word(8'hA2); write_word(8'hA3);
        check("rec3_length", 32'(length), 32'd3);
        rst = 1'b1; #2;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_length", 32'(length), 32'd0);
        step();
        rst = 1'b0; rec_en = 1'b0;
        check("rst_empty2", 32'(empty), 32'd1);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Record 3 notes, one-shot playback
        rec_en = 1'b1; step();
        check("rec_state", 32'(state), 32'd1);
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        rec_en = 1'b0; step();
        check("rec_done_length", 32'(length), 32'd3);
        check("rec_exit_state", 32'(state), 32'd0);
        loop_en = 1'b0; play_en = 1'b1; step();
        check("play_state", 32'(state), 32'd2);
        read_word("os0", 8'h11);
        read_word("os1", 8'h22);
        read_word("os2", 8'h33);
        check("os_done_state", 32'(state), 32'd3);
        check("os_play_done", 32'(play_done), 32'd1);
        rd_req = 1'b1; step(); rd_req = 1'b0;
        check("done_rd_valid", 32'(rd_valid), 32'd0);
        check("done_rd_data", 32'(rd_data), 32'd0);
        play_en = 1'b0; step();
        check("done_exit_state", 32'(state), 32'd0);

        // Loop playback
        loop_en = 1'b1; play_en = 1'b1; step();
        read_word("lp0", 8'h11);
        read_word("lp1", 8'h22);
        read_word("lp2", 8'h33);
        read_word("lp3", 8'h11);
        read_word("lp4", 8'h22);
        check("loop_state", 32'(state), 32'd2);
        step();
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        play_en = 1'b0; step();

        // Seek in IDLE, out-of-range seek, seek with read
        seek_en = 1'b1; seek_addr = 3'd2; step(); seek_en = 1'b0;
        play_en = 1'b1; step();
        read_word("seek2", 8'h33);
        seek_en = 1'b1; seek_addr = 3'd7; step(); seek_en = 1'b0;
        read_word("seek7", 8'h11);
        seek_en = 1'b1; seek_addr = 3'd0; step(); seek_en = 1'b0;
        seek_en = 1'b1; seek_addr = 3'd2;
        read_word("seek_rd_old", 8'h11);
        seek_en = 1'b0;
        read_word("seek_rd_new", 8'h33);
        play_en = 1'b0; step();

        // Conflicts and clear during play
        rec_en = 1'b1; play_en = 1'b1; step();
        check("both_en_state", 32'(state), 32'd0);
        rec_en = 1'b0; step();
        check("play_again_state", 32'(state), 32'd2);
        clear = 1'b1; rd_req = 1'b1; step(); clear = 1'b0; rd_req = 1'b0;
        check("clr_length", 32'(length), 32'd0);
        check("clr_state", 32'(state), 32'd0);
        check("clr_rd_valid", 32'(rd_valid), 32'd0);
        step();
        check("empty_play_state", 32'(state), 32'd0);
        play_en = 1'b0; step();

        // Full tape: six writes, only four stored
        do_clear();
        rec_en = 1'b1; step();
        for (int i = 1; i <= 6; i++) write_word(8'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_length", 32'(length), 32'd4);
        rec_en = 1'b0; step();
        loop_en = 1'b0; play_en = 1'b1; step();
        read_word("fp0", 8'd1);
        read_word("fp1", 8'd2);
        read_word("fp2", 8'd3);
        read_word("fp3", 8'd4);
        check("full_done_state", 32'(state), 32'd3);
        play_en = 1'b0; step();
        check("final_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tape_buffer_mem.md
Name: tape_buffer_mem

Overview:
- Parametrised record/playback note store; successor to the fixed 8x1024 single-port note memory.
- Adds auto-incrementing record and play pointers, a tracked tape length, loop/one-shot playback, seek, and a valid-qualified read path.
- Sits between the tape-scan decoder (record side) and the tone generator (play side).

Parameters:
- DATA_W, 8, width of one note word.
- ADDR_W, 10, pointer width.
- DEPTH, 1024, number of words. Must satisfy 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  sync pulse: empties the buffer. Highest priority after rst.
- rec_en  input  1  level: request record mode.
- play_en  input  1  level: request play mode.
- loop_en  input  1  1 = wrap at end of tape; 0 = stop at end of tape.
- wr_valid  input  1  write strobe, honoured in REC only.
- wr_data  input  DATA_W  note word to store.
- rd_req  input  1  read strobe, honoured in PLAY only.
- seek_en  input  1  load the play pointer; honoured in IDLE or PLAY.
- seek_addr  input  ADDR_W  seek target.
- rd_data  output  DATA_W  note word read; zero whenever rd_valid=0.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- length  output  ADDR_W+1  number of words stored (0..DEPTH).
- full  output  1  length==DEPTH.
- empty  output  1  length==0.
- play_done  output  1  high while in DONE.
- state  output  2  IDLE=0, REC=1, PLAY=2, DONE=3.

Behaviour:
- Reset (async, rst=1): state=IDLE; wr_ptr=0, rd_ptr=0, length=0; rd_data=0, rd_valid=0, play_done=0. Memory contents are not cleared.
- clear (rst=0): same register effect as reset, applied on the clock edge. Overrides every other input that cycle.
- IDLE transitions:
  - rec_en=1 and play_en=0 -> REC.
  - play_en=1 and rec_en=0 and length>0 -> PLAY. rd_ptr is unchanged, so a prior seek is kept.
  - Both rec_en and play_en=1 -> stay IDLE; no memory access.
  - play_en=1 with length=0 -> stay IDLE.
- REC:
  - wr_valid=1 and not full: mem[wr_ptr]<=wr_data; wr_ptr++; length++.
  - wr_valid=1 while full: write is dropped; no pointer or length change.
  - rec_en=0 -> IDLE; a wr_valid in that same cycle is still written.
  - Recording appends; re-entering REC continues at wr_ptr.
- PLAY:
  - rd_req=1: rd_data<=mem[rd_ptr] and rd_valid<=1 on the next edge (1-cycle latency).
  - If rd_ptr==length-1: with loop_en=1, rd_ptr<=0 and stay in PLAY; with loop_en=0, go to DONE.
  - Otherwise rd_ptr++.
  - seek_en=1 and rd_req=1 in the same cycle: the read uses the old rd_ptr, then rd_ptr<=seek_addr (seek wins over increment).
  - seek_addr>=length loads 0.
  - play_en=0 -> IDLE; a read requested that cycle still completes.
- DONE: play_done=1; rd_req is ignored. play_en=0 -> IDLE with rd_ptr<=0.
- Seek in IDLE: rd_ptr<=seek_addr if seek_addr<length, else 0.
- rd_valid=0 and rd_data=0 in every cycle without a completed read. The read port never returns stale data.
- Exactly one memory access per cycle. Writes occur only in REC, reads only in PLAY, so no read/write collision is possible.
- length is unsigned ADDR_W+1 bits and never exceeds DEPTH. wr_ptr never wraps; it saturates at DEPTH through the full block.
- rst or clear in the middle of REC or PLAY aborts immediately. Any read issued that cycle does not produce rd_valid.

Test Plan:
1. Reset: rst=1 mid-REC after 3 writes -> next cycle state=0, length=0, empty=1, rd_valid=0, rd_data=0.
2. Record/play: REC, write 0x11,0x22,0x33 -> length=3. PLAY with loop_en=0, 3 rd_req pulses -> rd_data 0x11,0x22,0x33, each one cycle after its req. Then state=3, play_done=1; a fourth rd_req gives no rd_valid. play_en=0 -> IDLE.
3. Loop: same tape, loop_en=1, 5 rd_req -> 0x11,0x22,0x33,0x11,0x22; state stays 2.
4. Full: DEPTH=4, write 6 words 1..6 -> full=1, length=4; playback returns 1,2,3,4.
5. Seek: length=3, seek_addr=2 in IDLE, then PLAY and rd_req -> 0x33. seek_addr=7 -> next read 0x11. rd_req+seek_en=1 with rd_ptr=0 -> returns 0x11, next read uses seek target.
6. Conflicts: rec_en=play_en=1 in IDLE -> state stays 0. clear during PLAY -> length=0, state=0; play_en with empty tape -> stays IDLE.
